// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store control stage.
//   - funct3 encodings for RISC-V loads/stores
//   - dmemory access-size encodings
//   - exception cause codes
//   - control FSM state type
//   - size_last(): byte count minus one for an access size
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RSP_HOLD  = 2'd2
  } lsu_state_e;

  // Offset of the last byte touched by an access, 33 bits wide so the
  // range check can see a carry out of the 32-bit address space.
  function automatic logic [32:0] size_last(input logic [1:0] sz);
    case (sz)
      SZ_H:    size_last = 33'd1;
      SZ_W:    size_last = 33'd3;
      default: size_last = 33'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: all handshake/bus signals around lsu_ctrl.
//   req_*  : request from execute (valid/ready)
//   flush  : kill any pending load
//   dm_*   : dmemory control/data
//   rsp_*  : load response to writeback (valid/ready)
//   exc_*  : exception pulse
// Modports: slave = lsu_ctrl, master = surrounding pipeline + dmemory.
interface lsu_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_rd;
  logic             flush;

  logic [31:0]      dm_addr;
  logic [31:0]      dm_data_in;
  logic [1:0]       dm_access_size;
  logic             dm_unsigned_sel;
  logic             dm_read_write;
  logic [31:0]      dm_data_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_rd;

  logic             exc_valid;
  logic [3:0]       exc_cause;
  logic [31:0]      exc_addr;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
           flush, dm_data_out, rsp_ready,
    output req_ready, dm_addr, dm_data_in, dm_access_size, dm_unsigned_sel,
           dm_read_write, rsp_valid, rsp_data, rsp_rd,
           exc_valid, exc_cause, exc_addr
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
           flush, dm_data_out, rsp_ready,
    input  req_ready, dm_addr, dm_data_in, dm_access_size, dm_unsigned_sel,
           dm_read_write, rsp_valid, rsp_data, rsp_rd,
           exc_valid, exc_cause, exc_addr
  );
endinterface

// File: rtl/lsu_decode.sv
// lsu_decode: combinational funct3 decode and access checking.
//   in : funct3, addr, is_store
//   out: access_size, unsigned_sel, err, cause (valid when err=1)
// Check priority: illegal funct3, then misalignment, then address range.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic        is_store,
  output logic [1:0]  access_size,
  output logic        unsigned_sel,
  output logic        err,
  output logic [3:0]  cause
);

  localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT33 = BASE33 + 33'(MEM_DEPTH);

  logic        legal;
  logic        misalign;
  logic        fault;
  logic [32:0] last;

  always_comb begin
    access_size  = funct3[1:0];
    unsigned_sel = funct3[2];

    if (is_store) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else          legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                          (funct3 == F3_BU) || (funct3 == F3_HU);

    misalign = ((access_size == SZ_H) && addr[0]) ||
               ((access_size == SZ_W) && (addr[1:0] != 2'b00));

    // 33-bit sum: an access running past 32'hFFFF_FFFF lands above LIMIT33.
    last  = {1'b0, addr} + size_last(access_size);
    fault = ({1'b0, addr} < BASE33) || (last >= LIMIT33);

    err   = !legal || misalign || fault;
    cause = 4'd0;
    if (!legal)        cause = CAUSE_ILLEGAL;
    else if (misalign) cause = is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else if (fault)    cause = is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store control in front of dmemory.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : request, flush, dmemory, response and exception signals
// One request at a time. dm_* are driven combinationally from req_* since
// dmemory registers its own inputs. Loads wait one cycle for dmemory's
// registered read, capture the data, then hold it until writeback takes it.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH = 1048576,
  parameter int          TAG_W     = 5
) (
  input  logic  clock,
  input  logic  reset_n,
  lsu_if.slave  bus
);

  lsu_state_e       state_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_rd_q;
  logic             exc_valid_q;
  logic [3:0]       exc_cause_q;
  logic [31:0]      exc_addr_q;

  logic [1:0] size;
  logic       usel;
  logic       err;
  logic [3:0] cause;
  logic       ready;
  logic       acc;

  lsu_decode #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_dec (
    .funct3       (bus.req_funct3),
    .addr         (bus.req_addr),
    .is_store     (bus.req_is_store),
    .access_size  (size),
    .unsigned_sel (usel),
    .err          (err),
    .cause        (cause)
  );

  assign ready = (state_q == IDLE);
  assign acc   = bus.req_valid && ready;

  assign bus.req_ready       = ready;
  assign bus.dm_addr         = bus.req_addr - BASE_ADDR;
  assign bus.dm_data_in      = bus.req_wdata;
  assign bus.dm_access_size  = size;
  assign bus.dm_unsigned_sel = usel;
  assign bus.dm_read_write   = acc && bus.req_is_store && !err;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_cause = exc_cause_q;
  assign bus.exc_addr  = exc_addr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      exc_valid_q <= 1'b0;
      if (acc && err) begin
        exc_valid_q <= 1'b1;
        exc_cause_q <= cause;
        exc_addr_q  <= bus.req_addr;
      end

      case (state_q)
        IDLE: begin
          // flush is ignored here: a same-cycle request still goes through.
          if (acc && !err && !bus.req_is_store) begin
            rsp_rd_q <= bus.req_rd;
            state_q  <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            // Capture now: dmemory re-latches whatever address is on
            // dm_addr every edge, so dm_data_out is only good this cycle.
            rsp_data_q  <= bus.dm_data_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP_HOLD;
          end
        end
        RSP_HOLD: begin
          if (bus.flush || bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a small registered-read
// dmemory model (64 bytes, little-endian, address masked to 6 bits).
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1048576;

  logic clock;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  lsu_if #(.TAG_W(5)) bus ();

  lsu_ctrl #(
    .BASE_ADDR (BASE),
    .MEM_DEPTH (DEPTH),
    .TAG_W     (5)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // dmemory model: writes and read capture both on the clock edge.
  logic [7:0]  mem [0:63];
  logic [31:0] dout_q;

  function automatic logic [31:0] rd_ext(input logic [5:0] i, input logic [1:0] sz,
                                         input logic u);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[i]; b1 = mem[i + 6'd1]; b2 = mem[i + 6'd2]; b3 = mem[i + 6'd3];
    case (sz)
      SZ_B:    rd_ext = u ? {24'd0, b0} : {{24{b0[7]}}, b0};
      SZ_H:    rd_ext = u ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: rd_ext = {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 64; k++) mem[k] <= 8'h00;
      mem[0] <= 8'hEF; mem[1] <= 8'hBE; mem[2] <= 8'hAD; mem[3] <= 8'hDE;
    end else if (bus.dm_read_write) begin
      mem[bus.dm_addr[5:0]] <= bus.dm_data_in[7:0];
      if (bus.dm_access_size != SZ_B) mem[bus.dm_addr[5:0] + 6'd1] <= bus.dm_data_in[15:8];
      if (bus.dm_access_size == SZ_W) begin
        mem[bus.dm_addr[5:0] + 6'd2] <= bus.dm_data_in[23:16];
        mem[bus.dm_addr[5:0] + 6'd3] <= bus.dm_data_in[31:24];
      end
    end
    dout_q <= rd_ext(bus.dm_addr[5:0], bus.dm_access_size, bus.dm_unsigned_sel);
  end
  assign bus.dm_data_out = dout_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0, rd);
    chk({tag, ".rdy"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".dmaddr"}, bus.dm_addr, a - BASE);
    chk({tag, ".rw"}, 32'(bus.dm_read_write), 32'd0);
    tick;
    bus.req_valid = 1'b0;
    chk({tag, ".wait"}, 32'(bus.rsp_valid), 32'd0);
    tick;
    chk({tag, ".vld"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".data"}, bus.rsp_data, exp);
    chk({tag, ".rd"}, 32'(bus.rsp_rd), 32'(rd));
    chk({tag, ".noexc"}, 32'(bus.exc_valid), 32'd0);
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk({tag, ".done"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    issue(1'b1, f3, a, wd, 5'd0);
    chk({tag, ".rw"}, 32'(bus.dm_read_write), 32'd1);
    chk({tag, ".din"}, bus.dm_data_in, wd);
    tick;
    bus.req_valid = 1'b0;
    #1;
    chk({tag, ".rw0"}, 32'(bus.dm_read_write), 32'd0);
    chk({tag, ".idle"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".norsp"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [3:0] cause);
    issue(st, f3, a, 32'hCAFE_F00D, 5'd1);
    chk({tag, ".rw"}, 32'(bus.dm_read_write), 32'd0);
    tick;
    bus.req_valid = 1'b0;
    #1;
    chk({tag, ".exc"}, 32'(bus.exc_valid), 32'd1);
    chk({tag, ".cause"}, 32'(bus.exc_cause), 32'(cause));
    chk({tag, ".eaddr"}, bus.exc_addr, a);
    chk({tag, ".idle"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".norsp"}, 32'(bus.rsp_valid), 32'd0);
    tick;
    chk({tag, ".pulse"}, 32'(bus.exc_valid), 32'd0);
    chk({tag, ".norsp2"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = F3_W;
    bus.req_addr     = BASE;
    bus.req_wdata    = 32'h0;
    bus.req_rd       = 5'd0;
    bus.flush        = 1'b0;
    bus.rsp_ready    = 1'b0;
    reset_n          = 1'b0;
    tick; tick;
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("rst.rsp_data", bus.rsp_data, 32'd0);
    chk("rst.rsp_rd", 32'(bus.rsp_rd), 32'd0);
    chk("rst.exc_cause", 32'(bus.exc_cause), 32'd0);
    chk("rst.exc_addr", bus.exc_addr, 32'd0);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    reset_n = 1'b1;
    tick;

    do_load("lw0", F3_W, BASE, 5'd7, 32'hDEAD_BEEF);

    // Backpressure: rsp held while requests and addresses churn.
    issue(1'b0, F3_W, BASE, 32'h0, 5'd3);
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("hold.vld", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, F3_W, BASE + 32'(4 * (i + 1)), 32'h5555_5555, 5'd9);
      chk("hold.rdy", 32'(bus.req_ready), 32'd0);
      chk("hold.rw", 32'(bus.dm_read_write), 32'd0);
      tick;
      chk("hold.data", bus.rsp_data, 32'hDEAD_BEEF);
      chk("hold.rd", 32'(bus.rsp_rd), 32'd3);
      chk("hold.vld2", 32'(bus.rsp_valid), 32'd1);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk("hold.rel", 32'(bus.rsp_valid), 32'd0);
    chk("hold.idle", 32'(bus.req_ready), 32'd1);

    // Flush while waiting on dmemory.
    issue(1'b0, F3_W, BASE, 32'h0, 5'd5);
    tick;
    bus.req_valid = 1'b0;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("flw.vld", 32'(bus.rsp_valid), 32'd0);
    chk("flw.idle", 32'(bus.req_ready), 32'd1);
    tick;
    chk("flw.vld2", 32'(bus.rsp_valid), 32'd0);

    // Flush while holding a response.
    issue(1'b0, F3_W, BASE, 32'h0, 5'd6);
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("flh.vld", 32'(bus.rsp_valid), 32'd1);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("flh.drop", 32'(bus.rsp_valid), 32'd0);
    chk("flh.idle", 32'(bus.req_ready), 32'd1);

    // Flush in IDLE does not block a same-cycle request.
    bus.flush = 1'b1;
    issue(1'b0, F3_W, BASE, 32'h0, 5'd9);
    tick;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("fli.busy", 32'(bus.req_ready), 32'd0);
    tick;
    chk("fli.vld", 32'(bus.rsp_valid), 32'd1);
    chk("fli.data", bus.rsp_data, 32'hDEAD_BEEF);
    chk("fli.rd", 32'(bus.rsp_rd), 32'd9);
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;

    do_store("sw4", F3_W, BASE + 32'd4, 32'h1234_5678);
    do_load("lw4", F3_W, BASE + 32'd4, 5'd10, 32'h1234_5678);
    do_store("sh8", F3_H, BASE + 32'd8, 32'hABCD_8001);
    do_load("lhu8", F3_HU, BASE + 32'd8, 5'd11, 32'h0000_8001);
    do_load("lh8", F3_H, BASE + 32'd8, 5'd12, 32'hFFFF_8001);
    do_store("sb3", F3_B, BASE + 32'd3, 32'h0000_0080);
    do_load("lb3", F3_B, BASE + 32'd3, 5'd13, 32'hFFFF_FF80);
    do_load("lbu3", F3_BU, BASE + 32'd3, 5'd14, 32'h0000_0080);
    do_load("lh2", F3_H, BASE + 32'd2, 5'd15, 32'hFFFF_80AD);
    do_load("lbtop", F3_B, BASE + DEPTH - 32'd1, 5'd16, 32'h0);
    do_load("lwtop", F3_W, BASE + DEPTH - 32'd4, 5'd17, 32'h0);

    do_err("lhmis", 1'b0, F3_H, BASE + 32'd1, CAUSE_LD_MISALIGN);
    do_err("swmis", 1'b1, F3_W, BASE + 32'd2, CAUSE_ST_MISALIGN);
    do_err("swlow", 1'b1, F3_W, 32'h00FF_FFFC, CAUSE_ST_FAULT);
    do_err("lwend", 1'b0, F3_W, BASE + DEPTH, CAUSE_LD_FAULT);
    do_err("ld011", 1'b0, 3'b011, BASE, CAUSE_ILLEGAL);
    do_err("lwwrap", 1'b0, F3_W, 32'hFFFF_FFFC, CAUSE_LD_FAULT);
    do_err("lhtop", 1'b0, F3_H, BASE + DEPTH - 32'd1, CAUSE_LD_MISALIGN);
    do_err("sh_end", 1'b1, F3_H, BASE + DEPTH - 32'd2 + 32'd2, CAUSE_ST_FAULT);
    do_err("st100", 1'b1, F3_BU, BASE + 32'd1, CAUSE_ILLEGAL);

    // Async reset during RSP_HOLD clears rsp_valid without a clock edge.
    issue(1'b0, F3_W, BASE + 32'd4, 32'h0, 5'd4);
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("ar.vld", 32'(bus.rsp_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar.vld0", 32'(bus.rsp_valid), 32'd0);
    chk("ar.data0", bus.rsp_data, 32'd0);
    chk("ar.idle", 32'(bus.req_ready), 32'd1);
    #1 reset_n = 1'b1;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of dmemory, in the MEM stage of the pipeline.
- Accepts one memory request at a time from execute over a valid/ready handshake.
- Decodes RISC-V funct3 into dmemory controls, checks alignment and address range, and translates the CPU address to a dmemory byte index.
- Absorbs dmemory's one-cycle registered-read latency and returns load data to writeback, with a tag and backpressure.

Parameters:
- BASE_ADDR, 32'h0100_0000, CPU address of dmemory byte 0.
- MEM_DEPTH, 1048576, dmemory size in bytes; must match dmemory `MEM_DEPTH.
- TAG_W, 5, width of the destination-register tag.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  request accepted on clock edge when req_valid && req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  32  effective CPU address.
- req_wdata  in  32  store data; byte/half taken from LSBs.
- req_rd  in  TAG_W  load destination tag.
- flush  in  1  kill any pending load.
- dm_addr  out  32  dmemory byte index, req_addr - BASE_ADDR.
- dm_data_in  out  32  equals req_wdata.
- dm_access_size  out  2  00 byte, 01 half, 10 word.
- dm_unsigned_sel  out  1  1 = zero-extend.
- dm_read_write  out  1  1 = write this edge.
- dm_data_out  in  32  dmemory read data, valid the cycle after the address is presented.
- rsp_valid  out  1  load result available.
- rsp_ready  in  1  writeback consumes the result.
- rsp_data  out  32  extended load data.
- rsp_rd  out  TAG_W  tag of the returned load.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault.
- exc_addr  out  32  faulting CPU address.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rsp_valid, exc_valid, rsp_data, rsp_rd, exc_cause and exc_addr all 0. The dm_* outputs are combinational and reset has no effect on them.
- Accept: acc = req_valid && req_ready; req_ready = (state==IDLE).
- dm_* outputs are combinational from req_* every cycle. dmemory registers its inputs, so no extra register is added here.
- dm_read_write = acc && req_is_store && !err; it is 0 in all other cycles.
- Funct3 decode:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other value is illegal.
  - dm_unsigned_sel = funct3[2]; dm_access_size = funct3[1:0].
- Error checks, in priority order:
  - illegal (cause 2);
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0 (cause 4 for load, 6 for store);
  - access fault: addr < BASE_ADDR, or addr+size-1 >= BASE_ADDR+MEM_DEPTH (cause 5 for load, 7 for store).
  - The range compare uses 33-bit arithmetic so that wrap-around at 32'hFFFF_FFFF faults.
- A request with an error is still accepted. It causes no write and produces no response. exc_valid pulses high in the cycle after acc, with exc_cause and exc_addr registered. The state stays IDLE.
- A valid store completes in the acc edge and produces no response; the state stays IDLE.
- Valid load, FSM:
  - IDLE -> LOAD_WAIT on acc; req_rd is latched.
  - LOAD_WAIT: dm_data_out is valid. On the next edge, rsp_data <= dm_data_out and rsp_valid <= 1, and the state goes to RSP_HOLD.
  - RSP_HOLD: rsp_data and rsp_rd are held stable. When rsp_ready=1, rsp_valid <= 0 and the state goes to IDLE.
- Latency: a load accepted at edge N gives rsp_valid=1 after edge N+1. The earliest next accept is the cycle after the handshake. Throughput is at most one load per 3 cycles.
- rsp_data is captured internally because dmemory re-latches its address every edge; the output must not depend on dm_data_out while in RSP_HOLD.
- flush=1 in LOAD_WAIT or RSP_HOLD: go to IDLE and set rsp_valid <= 0 with no response. flush has priority over rsp_ready and over the data capture.
- flush=1 in IDLE is ignored, so a same-cycle request is still accepted. Execute gates req_valid itself.
- No request is accepted while a load is pending, so a simultaneous request and pending response cannot occur.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants;
  - access-size encodings 00/01/10;
  - exception cause codes;
  - FSM state enum {IDLE, LOAD_WAIT, RSP_HOLD}.
- One combinational sub-module, lsu_decode: funct3, addr and is_store in; access_size, unsigned_sel, err and cause out.

Test Plan:
- Preload dmemory word 0 = 0xDEADBEEF; lw at 0x0100_0000, rd=7 -> rsp_valid 2 edges after accept, rsp_data=0xDEADBEEF, rsp_rd=7, dm_addr=0.
- sb 0x80 to 0x0100_0003, then lb at the same address -> 0xFFFFFF80; lbu -> 0x00000080; lh at 0x0100_0002 -> 0xFFFF80xx, with upper bytes from the preload.
- lh at 0x0100_0001 -> exc_valid one cycle, cause 4, exc_addr=0x0100_0001, no rsp_valid; sw at 0x0100_0002 -> cause 6 and dm_read_write never 1.
- sw at 0x00FF_FFFC -> cause 7; lw at BASE_ADDR+MEM_DEPTH -> cause 5; funct3=011 load -> cause 2; lw at 0xFFFF_FFFC -> cause 5.
- lw, hold rsp_ready=0 for 3 cycles while toggling req_addr -> rsp_data stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next edge.
- flush in LOAD_WAIT -> no rsp_valid and IDLE next edge. reset_n low during RSP_HOLD -> rsp_valid=0 immediately, not waiting for a clock edge.
